// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/response bundle between a core and the muldiv unit
interface muldiv_if;
  logic        start;
  logic        kill;
  logic [2:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, kill, op, in1, in2,
    input  busy, done, result
  );

  modport slave (
    input  start, kill, op, in1, in2,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative RV32M multiply/divide unit with fixed 33-cycle latency
module muldiv (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q;      // raw rs1, returned as remainder on divide-by-zero
  logic        a_neg;    // rs1 negative under this op's signedness
  logic        b_neg;    // rs2 negative under this op's signedness
  logic [63:0] acc;      // multiply: partial product; divide: {remainder, dividend/quotient}
  logic [63:0] mcand;    // multiply: shifted multiplicand magnitude
  logic [31:0] aux;      // multiply: remaining multiplier bits; divide: divisor magnitude
  logic [31:0] result_q;

  // Operand signedness and magnitudes, taken from the live inputs at the accept edge
  logic        in_a_signed;
  logic        in_b_signed;
  logic        in_a_neg;
  logic        in_b_neg;
  logic [31:0] in_a_mag;
  logic [31:0] in_b_mag;

  assign in_a_signed = (bus.op == 3'b001) || (bus.op == 3'b010) ||
                       (bus.op == 3'b100) || (bus.op == 3'b110);
  assign in_b_signed = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
  assign in_a_neg    = in_a_signed && bus.in1[31];
  assign in_b_neg    = in_b_signed && bus.in2[31];
  assign in_a_mag    = in_a_neg ? (~bus.in1 + 32'd1) : bus.in1;
  assign in_b_mag    = in_b_neg ? (~bus.in2 + 32'd1) : bus.in2;

  logic [63:0] acc_step;
  logic [63:0] mcand_step;
  logic [31:0] aux_step;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] final_res;

  // One radix-2 iteration plus sign fix-up of what the last iteration would produce
  always_comb begin
    acc_step   = acc;
    mcand_step = mcand;
    aux_step   = aux;
    rem_sh     = {acc[63:32], acc[31]};
    diff       = rem_sh - {1'b0, aux};
    prod       = 64'd0;
    quo        = 32'd0;
    rem        = 32'd0;
    final_res  = 32'd0;
    if (!op_q[2]) begin
      acc_step   = aux[0] ? (acc + mcand) : acc;
      mcand_step = {mcand[62:0], 1'b0};
      aux_step   = {1'b0, aux[31:1]};
      prod       = (a_neg ^ b_neg) ? (~acc_step + 64'd1) : acc_step;
      final_res  = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
    end else begin
      if (!diff[32]) acc_step = {diff[31:0], acc[30:0], 1'b1};
      else           acc_step = {rem_sh[31:0], acc[30:0], 1'b0};
      quo = (a_neg ^ b_neg) ? (~acc_step[31:0] + 32'd1) : acc_step[31:0];
      rem = a_neg ? (~acc_step[63:32] + 32'd1) : acc_step[63:32];
      if (aux == 32'd0) final_res = op_q[1] ? a_q : 32'hFFFF_FFFF;
      else              final_res = op_q[1] ? rem : quo;
    end
  end

  // Control FSM and datapath registers; kill takes priority over every other transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      op_q     <= 3'd0;
      a_q      <= 32'd0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      acc      <= 64'd0;
      mcand    <= 64'd0;
      aux      <= 32'd0;
      result_q <= 32'd0;
    end else if (bus.kill) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= RUN;
            cnt   <= 5'd0;
            op_q  <= bus.op;
            a_q   <= bus.in1;
            a_neg <= in_a_neg;
            b_neg <= in_b_neg;
            aux   <= in_b_mag;
            acc   <= bus.op[2] ? {32'd0, in_a_mag} : 64'd0;
            mcand <= {32'd0, in_a_mag};
          end
        end
        RUN: begin
          acc   <= acc_step;
          mcand <= mcand_step;
          aux   <= bus.op[2] ? aux : aux;
          if (!op_q[2]) aux <= aux_step;
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state    <= DONE;
            result_q <= final_res;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv.sv
// tb/tb_muldiv.sv - directed self-checking bench for muldiv
module tb_muldiv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  muldiv_if bus ();

  muldiv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op; verifies busy through the run, done on exactly the 32nd edge after accept,
  // the result, and return to idle one edge later. Optionally pulses start mid-run.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit pulse_start);
    int  n;
    bit  found;
    bit  busy_drop;
    @(negedge clk);
    bus.op = op; bus.in1 = a; bus.in2 = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.in1 = ~a; bus.in2 = ~b; bus.op = ~op;
    check({tag, "_busy_k"}, {31'd0, bus.busy}, 32'd1);
    n = 0; found = 1'b0; busy_drop = 1'b0;
    while (n < 40 && !found) begin
      @(posedge clk); #1;
      n++;
      if (pulse_start && (n == 5 || n == 20)) bus.start = 1'b1;
      else bus.start = 1'b0;
      if (!bus.busy) busy_drop = 1'b1;
      found = bus.done;
    end
    bus.start = 1'b0;
    check({tag, "_done_edge"}, n, 32);
    check({tag, "_busy_run"}, {31'd0, busy_drop}, 32'd0);
    check({tag, "_result"}, bus.result, exp);
    @(posedge clk); #1;
    check({tag, "_done_k33"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_busy_k33"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_hold"}, bus.result, exp);
  endtask

  initial begin
    int  n;
    bit  saw_done;
    bus.start = 1'b0; bus.kill = 1'b0; bus.op = 3'd0; bus.in1 = 32'd0; bus.in2 = 32'd0;

    // Reset state
    #12;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Multiply family
    do_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    do_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    do_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // Divide family, including zero divisor and signed overflow
    do_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    do_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    do_op("divu",   3'b101, 32'd100, 32'd7, 32'd14, 1'b0);
    do_op("remu",   3'b111, 32'd100, 32'd7, 32'd2, 1'b0);
    do_op("divu0",  3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    do_op("rem0",   3'b110, 32'd5, 32'd0, 32'd5, 1'b0);
    do_op("div0n",  3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b0);
    do_op("rem0n",  3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b0);
    do_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    do_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);

    // Start pulses during RUN must not queue a second operation
    do_op("mulst",  3'b000, 32'd6, 32'd9, 32'd54, 1'b1);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    check("no_queued_op", {31'd0, saw_done}, 32'd0);

    // Kill at the 10th RUN edge: idle immediately, no done, result unchanged
    @(negedge clk);
    bus.op = 3'b101; bus.in1 = 32'd1000; bus.in2 = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (n = 1; n < 10; n++) begin
      @(posedge clk); #1;
      if (n == 3) bus.start = 1'b1;
      else bus.start = 1'b0;
    end
    bus.start = 1'b0;
    bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    check("kill_busy", {31'd0, bus.busy}, 32'd0);
    check("kill_done", {31'd0, bus.done}, 32'd0);
    check("kill_result", bus.result, 32'd54);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    check("kill_no_done", {31'd0, saw_done}, 32'd0);
    check("kill_result_late", bus.result, 32'd54);

    // Asynchronous reset mid-run, then a fresh op at standard latency
    @(negedge clk);
    bus.op = 3'b000; bus.in1 = 32'd11; bus.in2 = 32'd13; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_result", bus.result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    do_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
